// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter slice.
package regfile_wb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int DROP_W   = 8;
    localparam int STARVE_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 4'd0;
    localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes plus the register-file write port they share.
interface regfile_wb_arbiter_if;
    import regfile_wb_pkg::*;

    logic              a_valid;
    logic [REG_W-1:0]  a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [REG_W-1:0]  b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              WriteReg;
    logic [REG_W-1:0]  DstReg;
    logic [DATA_W-1:0] DstData;
    logic              init_done;
    logic [DROP_W-1:0] drop_cnt;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, WriteReg, DstReg, DstData, init_done, drop_cnt
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, WriteReg, DstReg, DstData, init_done, drop_cnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_grant_2.sv
// Two-way combinational grant: round-robin, or A-priority with a starvation escape for B.
module wb_grant_2
    import regfile_wb_pkg::*;
#(
    parameter bit FIXED_PRIO   = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                aValid,
    input  logic                bValid,
    input  logic                lastGrantB,
    input  logic [STARVE_W-1:0] starveCnt,
    output logic [1:0]          grant
);

    always_comb begin
        grant = 2'b00;
        if (aValid && bValid) begin
            if (FIXED_PRIO)
                grant = (starveCnt == STARVE_W'(STARVE_LIMIT)) ? 2'b10 : 2'b01;
            else
                grant = lastGrantB ? 2'b01 : 2'b10;
        end else if (aValid) begin
            grant = 2'b01;
        end else if (bValid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: zero sweep of R1..R15 after reset, then
// arbitrates ALU (A) and load (B) writebacks with a one-cycle registered write.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter bit INIT_CLEAR   = 1'b1,
    parameter bit FIXED_PRIO   = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam state_t RESET_STATE = INIT_CLEAR ? INIT : RUN;

    function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    state_t              state;
    state_t              stateNext;
    logic [REG_W-1:0]    sweepCnt;
    logic [STARVE_W-1:0] starveCnt;
    logic                lastGrantB;
    logic [1:0]          grant;
    logic                aReady;
    logic                bReady;
    logic                accept;
    logic [REG_W-1:0]    selReg;
    logic [DATA_W-1:0]   selData;

    logic                wrVld_p1;
    logic [REG_W-1:0]    dstReg_p1;
    logic [DATA_W-1:0]   dstData_p1;
    logic                initDone_p1;
    logic [DROP_W-1:0]   dropCnt_p1;

    wb_grant_2 #(
        .FIXED_PRIO   (FIXED_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) uGrant (
        .aValid     (bus.a_valid),
        .bValid     (bus.b_valid),
        .lastGrantB (lastGrantB),
        .starveCnt  (starveCnt),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RESET_STATE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (state == INIT && sweepCnt == LAST_REG)
            stateNext = RUN;
    end

    always_comb begin
        aReady  = (state == RUN) && grant[0];
        bReady  = (state == RUN) && grant[1];
        accept  = (bus.a_valid && aReady) || (bus.b_valid && bReady);
        selReg  = aReady ? bus.a_reg  : bus.b_reg;
        selData = aReady ? bus.a_data : bus.b_data;
    end

    // Arbitration bookkeeping: sweep address, B starvation age, round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweepCnt   <= REG_W'(1);
            starveCnt  <= '0;
            lastGrantB <= 1'b1;
        end else begin
            if (state == INIT)
                sweepCnt <= sweepCnt + REG_W'(1);
            if (state == RUN && bus.b_valid && !bReady)
                starveCnt <= (&starveCnt) ? starveCnt : starveCnt + STARVE_W'(1);
            else
                starveCnt <= '0;
            if (bus.a_valid && aReady)
                lastGrantB <= 1'b0;
            else if (bus.b_valid && bReady)
                lastGrantB <= 1'b1;
        end
    end

    // Stage p1: registered register-file write; R0 targets are acknowledged but suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrVld_p1    <= 1'b0;
            dstReg_p1   <= '0;
            dstData_p1  <= '0;
            initDone_p1 <= 1'b0;
            dropCnt_p1  <= '0;
        end else begin
            initDone_p1 <= (stateNext == RUN);
            if (state == INIT) begin
                wrVld_p1   <= 1'b1;
                dstReg_p1  <= sweepCnt;
                dstData_p1 <= '0;
            end else if (accept) begin
                wrVld_p1   <= (selReg != REG_ZERO);
                dstReg_p1  <= selReg;
                dstData_p1 <= selData;
                if (selReg == REG_ZERO)
                    dropCnt_p1 <= satInc(dropCnt_p1);
            end else begin
                wrVld_p1 <= 1'b0;
            end
        end
    end

    assign bus.a_ready   = aReady;
    assign bus.b_ready   = bReady;
    assign bus.WriteReg  = wrVld_p1;
    assign bus.DstReg    = dstReg_p1;
    assign bus.DstData   = dstData_p1;
    assign bus.init_done = initDone_p1;
    assign bus.drop_cnt  = dropCnt_p1;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 16x16 register file (WriteReg/DstReg/DstData).
- Shares that port between two writeback requesters:
  - A: ALU/EX writeback.
  - B: memory/load writeback.
- After reset, sequences a zeroing sweep of R1..R15 before accepting requests.
- Sits between the pipeline writeback stage and the register file. Outputs drive the register file write inputs directly.

Parameters:
- INIT_CLEAR, 1: 1 = run the R1..R15 zero sweep after reset; 0 = go straight to RUN.
- FIXED_PRIO, 0: 0 = round-robin between A and B; 1 = A has priority, with starvation guard.
- STARVE_LIMIT, 4: with FIXED_PRIO=1, the number of consecutive cycles B may wait while valid before it is force-granted. Range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- a_valid  input  1  A has a write pending.
- a_reg  input  4  A destination register.
- a_data  input  16  A write data.
- a_ready  output  1  A accepted this cycle when a_valid&&a_ready.
- b_valid  input  1  B has a write pending.
- b_reg  input  4  B destination register.
- b_data  input  16  B write data.
- b_ready  output  1  B accepted this cycle when b_valid&&b_ready.
- WriteReg  output  1  register file write enable.
- DstReg  output  4  register file write address.
- DstData  output  16  register file write data.
- init_done  output  1  high once the arbiter is in RUN.
- drop_cnt  output  8  saturating count of accepted writes that targeted R0.

Behaviour:
- Reset (rst=0, asynchronous):
  - WriteReg=0, DstReg=0, DstData=0, init_done=0, drop_cnt=0.
  - Sweep counter=1, last-grant=B (so A wins first under round-robin), starve counter=0.
  - State = INIT if INIT_CLEAR=1, else RUN.
  - An in-flight write is discarded. Reset may occur mid-sweep or mid-stream; the sweep always restarts at R1.
- States: INIT, RUN. No other states. INIT is unreachable after leaving it except via reset.
- INIT:
  - a_ready=b_ready=0.
  - Each cycle, register the outputs as WriteReg=1, DstReg=cnt, DstData=0, then cnt++.
  - After the cycle that issues cnt=15, transition to RUN. The sweep is exactly 15 cycles.
  - init_done goes high on the first RUN cycle.
- RUN, ready generation (combinational from current valids and state):
  - Only a: grant A.
  - Only b: grant B.
  - Neither: no grant.
  - Both, FIXED_PRIO=0: grant the requester not granted last; last-grant updates on every accept.
  - Both, FIXED_PRIO=1: grant A unless starve counter == STARVE_LIMIT, in which case grant B.
  - Starve counter:
    - increments each cycle b_valid=1 and B is not granted;
    - clears when B is accepted or b_valid=0.
  - a_ready/b_ready are never both 1 in the same cycle.
  - Requesters must hold valid, reg and data stable until accepted. The arbiter never drops a request it has not acknowledged.
- Write timing: latency is 1 cycle. On the accept edge, register the outputs as WriteReg=1, DstReg=x_reg, DstData=x_data. When there is no accept, register WriteReg=0; DstReg/DstData hold their previous values.
- Throughput: one write per cycle. Back-to-back accepts produce consecutive WriteReg=1 cycles.
- R0 filter:
  - An accepted request with x_reg=0 is acknowledged normally.
  - The registered WriteReg is forced to 0 for that request.
  - drop_cnt increments, saturating at 255.
- Same-register conflict: when A and B target the same register in the same cycle, only the granted one writes that cycle. The other writes in a later cycle, so the last writer wins in grant order. There is no merging.
- Register-file read/write bypass is a register-file concern. This block makes no guarantee about same-cycle read data.

Decomposition:
- Package regfile_wb_pkg:
  - state enum {INIT, RUN};
  - REG_W=4, DATA_W=16, NUM_REGS=16, REG_ZERO=4'd0, DROP_W=8.
- One sub-module: wb_grant_2.
  - Inputs: valids, last-grant, starve counter, FIXED_PRIO.
  - Outputs: one-hot grant.
  - Purely combinational.
- The state register, sweep counter, starve counter, last-grant register and output registers stay in the top block.

Test Plan:
- INIT_CLEAR=1, release reset, a_valid=1 throughout -> 15 cycles of WriteReg=1 with DstReg=1..15 and DstData=0; a_ready=0 for the whole sweep; init_done=1 at cycle 16; the first A write appears the cycle after its accept.
- RUN, FIXED_PRIO=0, both valid continuously (A: R3=0x1111, B: R4=0x2222, each reloaded after accept) -> grants alternate A,B,A,B starting with A; WriteReg=1 every cycle; DstReg alternates 3,4.
- FIXED_PRIO=1, STARVE_LIMIT=4, a_valid and b_valid held high -> B is force-granted on its 5th waiting cycle; starve counter then clears; the next 4 grants go to A.
- A writes R0=0xBEEF and the same cycle B is idle -> a_ready=1; next cycle WriteReg=0; drop_cnt 0->1. Repeat 300 times -> drop_cnt=255.
- A and B both target R7 (0xAAAA, 0x5555) in the same cycle, round-robin with A granted first -> WriteReg cycles carry 0xAAAA then 0x5555 to R7.
- Assert rst low at sweep cycle 6, then release -> all outputs 0 immediately (asynchronous); the sweep restarts at DstReg=1 and takes a full 15 cycles.
